// File: rtl/tasks_round_collector.sv
// Round collector: records dispatched cores, pulses the generator's round ack once all have reported done,
// and captures the first hit with its reconstructed rdata. `define ROUND_TIMEOUT_EN adds a RUN watchdog and o_timeout.
module tasks_round_collector #(
  parameter int unsigned CORES_QNT = 4
`ifdef ROUND_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_gen_term,
  input  logic                  i_task_nf,
  input  logic [15:0]           i_task_core_num,
  input  logic [31:0][7:0]      i_task_rdata_1,
  input  logic [31:0][7:0]      i_task_rdata_2,
  input  logic [CORES_QNT-1:0]  i_core_done,
  input  logic [CORES_QNT-1:0]  i_core_found,
  output logic                  o_tasks_sr_ack,
  output logic                  o_found_vld,
  output logic [15:0]           o_found_core,
  output logic [31:0][7:0]      o_found_rdata_1,
  output logic [31:0][7:0]      o_found_rdata_2,
  input  logic                  i_found_ack,
  output logic [15:0]           o_found_drop_cnt,
  output logic [31:0]           o_round_cnt,
  output logic                  o_bf
`ifdef ROUND_TIMEOUT_EN
  , output logic                o_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

  state_t               state, state_n;
  logic [CORES_QNT-1:0] dispatched, dispatched_n;
  logic [CORES_QNT-1:0] pending, pending_n;
  logic [CORES_QNT-1:0] disp_bit, hits;
  logic [511:0]         base_rdata, base_n;
  logic [511:0]         found_rdata, found_n;
  logic                 task_ok, capture;
  logic [15:0]          hit_idx, top16;
  logic [16:0]          hit_cnt, drop_add;
  logic [17:0]          drop_sum;
`ifdef ROUND_TIMEOUT_EN
  logic [31:0]          wd_cnt;
  logic                 timeout_hit;
`endif

  assign task_ok = i_task_nf && ({16'd0, i_task_core_num} < CORES_QNT);
  assign hits    = i_core_done & i_core_found;
  assign o_bf    = (pending != '0);

  always_comb begin
    disp_bit = '0;
    for (int k = 0; k < int'(CORES_QNT); k++)
      disp_bit[k] = task_ok && (i_task_core_num == 16'(k));
  end

`ifdef ROUND_TIMEOUT_EN
  assign timeout_hit = (wd_cnt == TIMEOUT_CYCLES - 32'd1);
`endif

  // A same-cycle dispatch re-arms the pending bit after the done clears it.
  always_comb begin
    state_n        = state;
    pending_n      = (pending & ~i_core_done) | disp_bit;
    dispatched_n   = dispatched | disp_bit;
    base_n         = (task_ok && i_task_core_num == 16'd0) ? {i_task_rdata_2, i_task_rdata_1} : base_rdata;
    o_tasks_sr_ack = 1'b0;
    case (state)
      IDLE: if (task_ok) state_n = RUN;
      RUN: begin
        if (pending == '0 && !i_task_nf && dispatched != '0) state_n = ACK;
`ifdef ROUND_TIMEOUT_EN
        else if (timeout_hit) begin
          state_n   = ACK;
          pending_n = '0;
        end
`endif
      end
      ACK: begin
        o_tasks_sr_ack = 1'b1;
        dispatched_n   = disp_bit;
        state_n        = task_ok ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (i_gen_term) begin
      o_tasks_sr_ack = 1'b0;
      state_n        = IDLE;
      pending_n      = '0;
      dispatched_n   = '0;
      base_n         = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state       <= IDLE;
      pending     <= '0;
      dispatched  <= '0;
      base_rdata  <= '0;
      o_round_cnt <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      dispatched <= dispatched_n;
      base_rdata <= base_n;
      if (o_tasks_sr_ack) o_round_cnt <= o_round_cnt + 32'd1;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else if (i_gen_term) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == RUN) ? wd_cnt + 32'd1 : 32'd0;
      if (state == RUN && state_n == ACK && timeout_hit) o_timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    hit_idx = '0;
    hit_cnt = '0;
    for (int k = int'(CORES_QNT) - 1; k >= 0; k--)
      if (hits[k]) hit_idx = 16'(k);
    for (int k = 0; k < int'(CORES_QNT); k++)
      hit_cnt = hit_cnt + 17'(hits[k]);
  end

  // Bytes 62 (high) and 63 (low) form a 16-bit field that absorbs the core index with carry.
  assign top16    = {base_rdata[503:496], base_rdata[511:504]} + hit_idx;
  assign found_n  = {top16[7:0], top16[15:8], base_rdata[495:0]};
  assign capture  = (hits != '0) && (!o_found_vld || i_found_ack);
  assign drop_add = capture ? hit_cnt - 17'd1 : hit_cnt;
  assign drop_sum = 18'(o_found_drop_cnt) + 18'(drop_add);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      o_found_vld      <= 1'b0;
      o_found_core     <= '0;
      found_rdata      <= '0;
      o_found_drop_cnt <= '0;
    end else begin
      if (capture) begin
        o_found_vld  <= 1'b1;
        o_found_core <= hit_idx;
        found_rdata  <= found_n;
      end else if (i_found_ack) begin
        o_found_vld <= 1'b0;
      end
      o_found_drop_cnt <= (drop_sum > 18'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign o_found_rdata_1 = found_rdata[255:0];
  assign o_found_rdata_2 = found_rdata[511:256];

endmodule
